// File: rtl/regfile_read_arbiter_pkg.sv
// Shared register-file types and constants for the read-port arbiter slice.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG_IDX = 5'd31;

  // Architectural value of a read: XZR reads as zero when the feature is enabled.
  function automatic reg_data_t read_value(input reg_addr_t addr, input reg_data_t raw, input logic zero_en);
    if (zero_en && (addr == ZERO_REG_IDX)) begin
      return {REG_DATA_W{1'b0}};
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Request/response bundle between requesters, the register-file mux and the arbiter.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import regfile_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  reg_addr_t                     rf_sel;
  reg_data_t                     rf_data;
  logic                          rsp_valid;
  logic                          rsp_ready;
  reg_data_t                     rsp_data;
  logic [ID_W-1:0]               rsp_id;
  reg_addr_t                     rsp_addr;

  modport master (
    output req_valid, req_addr, rf_data, rsp_ready,
    input  req_ready, rf_sel, rsp_valid, rsp_data, rsp_id, rsp_addr
  );

  modport slave (
    input  req_valid, req_addr, rf_data, rsp_ready,
    output req_ready, rf_sel, rsp_valid, rsp_data, rsp_id, rsp_addr
  );

endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: highest priority at rr_ptr, rising with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  logic found_s;

  // Scan priority offsets k = 0..NUM_REQ-1 and take the first requesting slot.
  always_comb begin
    grant   = {NUM_REQ{1'b0}};
    winner  = {ID_W{1'b0}};
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (enable && !found_s && req[i] && (i == ((int'(rr_ptr) + k) % NUM_REQ))) begin
          grant[i] = 1'b1;
          winner   = ID_W'(i);
          found_s  = 1'b1;
        end else begin
        end
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of one register-file read port with a 2-stage tagged response pipe.
// Optional macro REGFILE_ZERO_REG_EN: index 31 reads as zero.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  regfile_read_arbiter_if.slave bus
);

  logic [ID_W-1:0]    rr_ptr_r;
  logic               s1_valid_r;
  reg_addr_t          s1_addr_r;
  logic [ID_W-1:0]    s1_id_r;
  logic               s2_valid_r;
  reg_data_t          s2_data_r;
  logic [ID_W-1:0]    s2_id_r;
  reg_addr_t          s2_addr_r;

  logic               s1_advance_s;
  logic               can_accept_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    winner_s;
  logic               handshake_s;
  reg_addr_t          win_addr_s;
  reg_data_t          rd_data_s;
  logic               zero_en_s;

  assign s1_advance_s = s1_valid_r & (~s2_valid_r | bus.rsp_ready);
  assign can_accept_s = ~s1_valid_r | s1_advance_s;

  // Gating with reset_n keeps req_ready low for the whole reset window.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_r),
    .enable (can_accept_s & reset_n),
    .grant  (grant_s),
    .winner (winner_s)
  );

  assign handshake_s   = |grant_s;
  assign bus.req_ready = grant_s;

  // Address of the granted requester.
  always_comb begin
    win_addr_s = 5'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        win_addr_s = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
      end else begin
      end
    end
  end

`ifdef REGFILE_ZERO_REG_EN
  assign zero_en_s = 1'b1;
`else
  assign zero_en_s = 1'b0;
`endif

  assign rd_data_s = read_value(s1_addr_r, bus.rf_data, zero_en_s);

  // Pipeline state: arbitration pointer, mux-access stage and response register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_r   <= {ID_W{1'b0}};
      s1_valid_r <= 1'b0;
      s1_addr_r  <= 5'd0;
      s1_id_r    <= {ID_W{1'b0}};
      s2_valid_r <= 1'b0;
      s2_data_r  <= 32'd0;
      s2_id_r    <= {ID_W{1'b0}};
      s2_addr_r  <= 5'd0;
    end else begin
      if (handshake_s) begin
        s1_valid_r <= 1'b1;
        s1_addr_r  <= win_addr_s;
        s1_id_r    <= winner_s;
        rr_ptr_r   <= (int'(winner_s) == NUM_REQ - 1) ? {ID_W{1'b0}} : winner_s + 1'b1;
      end else if (s1_advance_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end

      if (s1_advance_s) begin
        s2_valid_r <= 1'b1;
        s2_data_r  <= rd_data_s;
        s2_id_r    <= s1_id_r;
        s2_addr_r  <= s1_addr_r;
      end else if (s2_valid_r && bus.rsp_ready) begin
        s2_valid_r <= 1'b0;
      end else begin
        s2_valid_r <= s2_valid_r;
      end
    end
  end

  assign bus.rf_sel    = s1_addr_r;
  assign bus.rsp_valid = s2_valid_r;
  assign bus.rsp_data  = s2_data_r;
  assign bus.rsp_id    = s2_id_r;
  assign bus.rsp_addr  = s2_addr_r;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed + random bench for regfile_read_arbiter against a queue-based transaction model.
module tb_regfile_read_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;

  typedef struct {
    int          id;
    logic [4:0]  addr;
    logic [31:0] data;
    int          t;
  } item_t;

  logic clk = 1'b0;
  logic reset_n;
  logic ones_mode;

  regfile_read_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

  regfile_read_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.rf_data = ones_mode ? 32'hFFFFFFFF : (32'hA5A50000 | {27'd0, bus.rf_sel});

  int         vectors = 0;
  int         miscompares = 0;
  item_t      q[$];
  int         ptr = 0;
  logic [4:0] last_addr = 5'd0;
  int         cyc = 0;
  bit         hs_flag;
  bit         dut_pop;

  function automatic logic [31:0] exp_data(input logic [4:0] a);
`ifdef REGFILE_ZERO_REG_EN
    if (a == 5'd31) return 32'd0;
`endif
    return ones_mode ? 32'hFFFFFFFF : (32'hA5A50000 | {27'd0, a});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic [NR-1:0] eg;
    int            w;
    bit            can;
    bit            vis;
    item_t         it;
    eg = '0;
    w = 0;
    @(negedge clk);
    if (reset_n) begin
      can = (q.size() < 2) || bus.rsp_ready;
      if (can) begin
        for (int k = 0; k < NR; k++) begin
          if (eg == '0 && bus.req_valid[(ptr + k) % NR]) begin
            w = (ptr + k) % NR;
            eg[w] = 1'b1;
          end
        end
      end
    end
    chk("req_ready", {28'd0, bus.req_ready}, {28'd0, eg});
    chk("rf_sel", {27'd0, bus.rf_sel}, {27'd0, last_addr});
    vis = (q.size() > 0) && (cyc >= q[0].t + 2);
    chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, vis});
    if (vis) begin
      chk("rsp_data", bus.rsp_data, q[0].data);
      chk("rsp_id", {30'd0, bus.rsp_id}, 32'(q[0].id));
      chk("rsp_addr", {27'd0, bus.rsp_addr}, {27'd0, q[0].addr});
    end
    dut_pop = bus.rsp_valid && bus.rsp_ready;
    hs_flag = 1'b0;
    if (!reset_n) begin
      q.delete();
      ptr = 0;
      last_addr = 5'd0;
    end else begin
      if (vis && bus.rsp_ready) void'(q.pop_front());
      if (eg != '0) begin
        it.id   = w;
        it.addr = bus.req_addr[w*5 +: 5];
        it.data = exp_data(it.addr);
        it.t    = cyc;
        q.push_back(it);
        ptr = (w + 1) % NR;
        last_addr = it.addr;
        hs_flag = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int total;
    int stall;
    int pops;
    bit first;

    ones_mode     = 1'b0;
    reset_n       = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_addr  = 20'd0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with all requesters asking, then idle after release.
    for (int c = 0; c < 3; c++) step();
    reset_n = 1'b1;
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 3; c++) step();

    // Single read: req0 addr 7.
    bus.req_valid = 4'b0001;
    bus.req_addr  = {5'd0, 5'd0, 5'd0, 5'd7};
    step();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) step();

    // Round-robin with all four requesters valid.
    bus.req_valid = 4'b1111;
    bus.req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 10; c++) step();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) step();

    // Back-pressure: 5 reads, rsp_ready low for 4 cycles after the first response.
    total = 0; stall = 0; pops = 0; first = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.req_addr  = {15'd0, 5'(10 + total)};
      bus.req_valid = (total < 5) ? 4'b0001 : 4'b0000;
      bus.rsp_ready = !(first && stall < 4);
      step();
      if (hs_flag) total++;
      if (first && !bus.rsp_ready) stall++;
      if (dut_pop) begin
        pops++;
        first = 1'b1;
      end
    end
    chk("bp_handshakes", 32'(total), 32'd5);
    chk("bp_responses", 32'(pops), 32'd5);
    bus.rsp_ready = 1'b1;

    // Reset with s1 and s2 both occupied.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_addr  = {5'd0, 5'd0, 5'd9, 5'd0};
    for (int c = 0; c < 3; c++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

    // Zero register read through requester 2 with the mux returning all ones.
    ones_mode = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_addr  = {5'd0, 5'd31, 5'd0, 5'd0};
    step();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) step();
    ones_mode = 1'b0;

    // Random traffic with occasional back-pressure and resets.
    for (int c = 0; c < 500; c++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.req_addr  = 20'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      reset_n       = ($urandom_range(0, 99) != 0);
      step();
    end
    reset_n = 1'b1;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares one read port of the 32x32 register file (the 32:1 word mux, driven through its 5-bit select) among NUM_REQ requesters.
- Requesters can be the fetch/decode read, the forwarding unit, the debug reader and so on.
- Arbitration is round-robin with a valid/ready handshake on the request side.
- Read results return through a 2-stage pipeline with back-pressure and requester ID tagging.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*5  per-requester register index; slice i = bits [5i+4:5i].
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] & req_ready[i].
- rf_sel  out  5  select to the register-file read mux.
- rf_data  in  32  mux output for the current rf_sel; combinational, same cycle.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  read data.
- rsp_id  out  ID_W  index of the requester that issued the read.
- rsp_addr  out  5  register index that was read.

Behaviour:
- Reset (reset_n=0 at an edge):
  - s1_valid=0, s2_valid=0, rr_ptr=0.
  - rf_sel=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_addr=0.
  - req_ready is all-zero while reset_n=0.
  - Reset mid-operation discards all in-flight reads; no response is produced for them.
- Stage 0 (arbitration, combinational):
  - can_accept = !s1_valid | s1_advance.
  - If can_accept, grant the first i with req_valid[i] set, searching upward from rr_ptr with wrap-around modulo NUM_REQ.
  - req_ready = one-hot of that winner, else 0.
  - req_ready never asserts for a requester whose req_valid is low.
- On handshake:
  - s1_addr <= req_addr[winner], s1_id <= winner, s1_valid <= 1.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no handshake.
- Stage 1 (mux access):
  - rf_sel is driven from the s1_addr register, so it holds for as long as s1 holds.
  - s1_advance = s1_valid & (!s2_valid | rsp_ready).
  - On s1_advance: s2_data <= rf_data, s2_id <= s1_id, s2_addr <= s1_addr, s2_valid <= 1.
  - If a handshake does not occur in the same cycle, s1_valid <= 0.
- Stage 2 (response register):
  - rsp_* = s2_*.
  - On rsp_valid & rsp_ready with no s1_advance, s2_valid <= 0.
  - Simultaneous drain and refill keeps s2_valid=1 with the new data.
  - While stalled (rsp_valid=1, rsp_ready=0), rsp_data/rsp_id/rsp_addr are stable.
- Latency: a handshake in cycle N gives rsp_valid in cycle N+2 when there is no back-pressure.
- Throughput: 1 read/cycle sustained.
- Full pipeline (s1 and s2 valid, rsp_ready=0): req_ready=0, rf_sel held, nothing lost or duplicated.
- Fairness: a requester holding req_valid is granted within NUM_REQ accepting cycles.
- Responses return in grant order; no reordering.
- rf_data is assumed stable for the whole cycle; register-file writes are outside this block's scope.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: a read of index 31 (XZR) returns rsp_data=0 regardless of rf_data. Timing and handshake are unchanged, and rf_sel is still driven to 31.
- Undefined: index 31 returns rf_data like any other register.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG_IDX=31.
  - typedef reg_addr_t (logic [4:0]) and reg_data_t (logic [31:0]).
- Sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: req vector, rr_ptr, enable.
  - outputs: one-hot grant and encoded winner index.
  - purely combinational; rr_ptr state stays in the parent.

Test Plan:
- Reset/idle:
  - hold reset_n=0 3 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rf_sel=0.
  - release with no requests -> outputs stay idle.
- Single read latency:
  - bench mux model returns 32'hA5A50000|sel.
  - req0 addr=7 handshake in cycle N -> rf_sel=7 in N+1; rsp_valid in N+2 with rsp_data=32'hA5A50007, rsp_id=0, rsp_addr=7.
- Round-robin:
  - all four requesters valid continuously, addrs 1,2,3,4, rsp_ready=1 -> grants cycle 0,1,2,3,0,...
  - rsp_id sequence 0,1,2,3,0 with one response per cycle.
- Back-pressure:
  - stream 5 reads, drop rsp_ready for 4 cycles after the first response -> req_ready=0 once s1/s2 are full.
  - rsp_data stable during the stall; all 5 responses delivered in order, no loss or duplication.
- Reset mid-flight: assert reset_n=0 with s1 and s2 valid -> next cycle rsp_valid=0; no stale response after release.
- Zero register: req2 addr=31, model returns 32'hFFFFFFFF -> rsp_data=0 with REGFILE_ZERO_REG_EN, 32'hFFFFFFFF without.
